button_conditioner: RTL
=======================

# button_conditioner

Per-button input stage that sits directly upstream of the counter-control FSM in the top design. It synchronises a raw active-high button signal into `clk`, debounces it with a four-state machine, and emits a clean level plus single-cycle press/release pulses. Optionally, it also emits a long-press pulse. The top design uses one instance per button; `press` drives the FSM's go/pause pulse inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 240000 — cycles the synchronised input must stay stable before a transition is accepted (20 ms at 12 MHz); must be ≥ 1.
- `HOLD_CYCLES`, default 12000000 — cycles in the pressed state before `hold` fires (1 s at 12 MHz); must be ≥ 1; used only with `BTN_HOLD_EN`.
- `CNT_WIDTH`, default 24 — width of the internal counters; must hold both `DEBOUNCE_CYCLES-1` and `HOLD_CYCLES-1`.
- `clk` input 1 — system clock.
- `rst` input 1 — synchronous, active-high reset.
- `noisy` input 1 — raw button, active-high (already inverted from the pin), asynchronous to `clk`.
- `level` output 1 — debounced button state (registered).
- `press` output 1 — one-cycle pulse on an accepted press.
- `release` output 1 — one-cycle pulse on an accepted release.
- `hold` output 1 — one-cycle pulse after a press lasts `HOLD_CYCLES` cycles; constant 0 without `BTN_HOLD_EN`.

## Operation
- Two-flop synchroniser `noisy` → `s1` → `s2`. Only `s2` feeds the FSM.
- Debounce counter `dcnt`, CNT_WIDTH bits.
- FSM states:
  - `S_RELEASED`: `level`=0. If `s2`=1 → `S_PRESS_WAIT`, `dcnt`←0.
  - `S_PRESS_WAIT`: `level`=0.
    - If `s2`=0 → `S_RELEASED` (bounce rejected, no pulse).
    - Else if `dcnt`==DEBOUNCE_CYCLES-1 → `S_PRESSED`, `press`←1, `level`←1.
    - Else `dcnt`++.
  - `S_PRESSED`: `level`=1. If `s2`=0 → `S_RELEASE_WAIT`, `dcnt`←0.
  - `S_RELEASE_WAIT`: `level`=1.
    - If `s2`=1 → `S_PRESSED` (glitch rejected; the hold counter is not cleared).
    - Else if `dcnt`==DEBOUNCE_CYCLES-1 → `S_RELEASED`, `release`←1, `level`←0.
    - Else `dcnt`++.
  - Illegal encoding → `S_RELEASED`, all outputs 0.
- Rules for `press`, `release` and `hold`:
  - All three are registered and default to 0 every cycle.
  - Each pulse lasts exactly one cycle.
  - `press` and `release` never assert in the same cycle.
- The counter never wraps: it stops at its terminal compare.
- Any input activity shorter than DEBOUNCE_CYCLES cycles produces no output change.

## Timing
- Reset (synchronous): `s1`=`s2`=0, state `S_RELEASED`, `dcnt`=0, hold counter 0. `level`=`press`=`release`=`hold`=0 in the cycle after the reset edge.
- Press latency: first edge sampling `noisy`=1 is edge E0. `press` and `level` rise after edge E0+DEBOUNCE_CYCLES+2, provided `noisy` stays 1 throughout.
- Release latency: symmetric; `release` pulses and `level` falls after edge E0+DEBOUNCE_CYCLES+2.
- Button held through reset: after reset deasserts, it is treated as a new press, and `press` fires after the full latency.
- Reset mid-debounce or mid-press: the state is discarded and no `release` pulse is generated.

## Configuration
- Macro: `BTN_HOLD_EN`.
- Defined: a hold counter (CNT_WIDTH bits) clears on entry to `S_PRESSED` from `S_PRESS_WAIT`.
  - It increments each cycle in `S_PRESSED` or `S_RELEASE_WAIT`.
  - When it equals HOLD_CYCLES-1, `hold` pulses once and the counter saturates.
  - No further `hold` pulses occur until the next accepted press.
  - An accepted release clears the counter.
- Undefined: the hold counter is not synthesised and `hold` is tied to 0.

## Test plan
- DEBOUNCE_CYCLES=4, `noisy` rises at E0 and stays high → `press` high for exactly one cycle after edge E0+6; `level`=1 from the same cycle.
- DEBOUNCE_CYCLES=4, `noisy` high for 3 cycles then low → `level`, `press` and `release` stay 0 throughout.
- After an accepted press, `noisy` low for 2 cycles then high again → no `release`; `level` stays 1; then a stable low for ≥ 6 cycles → exactly one `release` pulse and `level`=0.
- `BTN_HOLD_EN` defined, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, button held 40 cycles → exactly one `hold` pulse, 10 cycles after `press`; without the macro, `hold` stays 0.
- `rst` asserted for 1 cycle while `level`=1 → all outputs 0 the next cycle with no `release` pulse; with the button still held, `press` reasserts 6 cycles after reset deasserts.
- Synchroniser check: `noisy` pulse of 1 cycle at any phase → no output activity.

Source files
------------

// File: rtl/button_conditioner.sv
// Button input stage: two-flop synchroniser, four-state debounce FSM, clean level plus press/release pulses.
// Define BTN_HOLD_EN to add a one-shot long-press `hold` pulse; otherwise hold_o is tied low.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned HOLD_CYCLES     = 12000000,
  parameter int unsigned CNT_WIDTH       = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic noisy_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 s1_q, s2_q;
  logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;

  // Synchroniser, FSM state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= S_RELEASED;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= noisy_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state and output decode; the counter holds at its terminal value
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (s2_q) begin
          state_d = S_PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = S_RELEASED;
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_WIDTH'(1);
        end
      end
      S_PRESSED: begin
        if (!s2_q) begin
          state_d = S_RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = S_PRESSED;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_RELEASED;
        dcnt_d  = '0;
      end
    endcase
    level_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_HOLD_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic                 hdone_q, hdone_d;
  logic                 hold_q, hold_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q  <= '0;
      hdone_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      hdone_q <= hdone_d;
      hold_q  <= hold_d;
    end
  end

  // Counts while the button is debounced-down; glitches in RELEASE_WAIT do not restart it
  always_comb begin
    hcnt_d  = hcnt_q;
    hdone_d = hdone_q;
    hold_d  = 1'b0;
    if ((state_q == S_PRESSED || state_q == S_RELEASE_WAIT) && !release_d) begin
      if (hcnt_q != HOLD_LAST) begin
        hcnt_d = hcnt_q + CNT_WIDTH'(1);
      end else if (!hdone_q) begin
        hold_d  = 1'b1;
        hdone_d = 1'b1;
      end
    end else begin
      hcnt_d  = '0;
      hdone_d = 1'b0;
    end
  end

  assign hold_o = hold_q;
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^32'(HOLD_CYCLES);
  assign hold_o          = 1'b0;
`endif

endmodule
